// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : frame_sequencer
//  Purpose  : Paced INPUT -> ACTION -> DISPLAY controller. Each frame starts
//             on a frame-rate tick and uses enable/done handshakes. A
//             per-stage watchdog aborts a stalled stage.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_sequencer #(
  parameter int FRAME_CYCLES = 16,
  parameter int TIMEOUT      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       pause_i,
  output logic       e_inp_o,
  input  logic       d_inp_i,
  output logic       e_act_o,
  input  logic       d_act_i,
  output logic       e_disp_o,
  input  logic       d_disp_i,
  output logic [1:0] state_o,
  output logic       busy_o,
  output logic [7:0] frame_cnt_o,
  output logic       timeout_o,
  output logic [1:0] err_stage_o,
  output logic       overrun_o
);

  // Phase codes are visible on state_o and err_stage_o.
  typedef enum logic [1:0] {
    S_WAIT    = 2'b00,
    S_INPUT   = 2'b01,
    S_ACTION  = 2'b11,
    S_DISPLAY = 2'b10
  } state_t;

  localparam int TW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] C_TICK_VAL = TW'(FRAME_CYCLES - 1);
  // With TIMEOUT == 0 the compare value is irrelevant because C_WD_EN masks it.
  localparam logic [CW-1:0] C_TO_LAST  = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic          C_WD_EN    = (TIMEOUT != 0);

  state_t          r_state;
  state_t          w_state_nx;
  logic [TW-1:0]   r_timer;
  logic [CW-1:0]   r_stage_cnt;
  logic            w_tick;
  logic            w_stage_done;
  logic            w_frame_done;
  logic            w_fault;
  logic            w_wd_expire;

  assign w_tick      = (r_timer == C_TICK_VAL);
  assign w_wd_expire = C_WD_EN && (r_stage_cnt == C_TO_LAST);
  assign state_o     = r_state;
  assign busy_o      = (r_state != S_WAIT);

  // Only the done belonging to the currently enabled stage is observed.
  always_comb begin
    w_stage_done = 1'b0;
    case (r_state)
      S_INPUT:   w_stage_done = d_inp_i;
      S_ACTION:  w_stage_done = d_act_i;
      S_DISPLAY: w_stage_done = d_disp_i;
      default:   w_stage_done = 1'b0;
    endcase
  end

  // Next-state decode; a done in the expiry cycle beats the watchdog.
  always_comb begin
    w_state_nx   = r_state;
    w_frame_done = 1'b0;
    w_fault      = 1'b0;
    if (r_state == S_WAIT) begin
      if (w_tick && !pause_i) begin
        w_state_nx = S_INPUT;
      end
    end else if (w_stage_done) begin
      case (r_state)
        S_INPUT:  w_state_nx = S_ACTION;
        S_ACTION: w_state_nx = S_DISPLAY;
        default: begin
          w_state_nx   = S_WAIT;
          w_frame_done = 1'b1;
        end
      endcase
    end else if (w_wd_expire) begin
      w_state_nx = S_WAIT;
      w_fault    = 1'b1;
    end
  end

  // State register; everything holds while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT;
    end else if (ena) begin
      r_state <= w_state_nx;
    end
  end

  // Frame timer, stage watchdog counter, registered enables and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer     <= '0;
      r_stage_cnt <= '0;
      e_inp_o     <= 1'b0;
      e_act_o     <= 1'b0;
      e_disp_o    <= 1'b0;
      frame_cnt_o <= 8'd0;
      timeout_o   <= 1'b0;
      err_stage_o <= 2'b00;
      overrun_o   <= 1'b0;
    end else if (ena) begin
      r_timer <= w_tick ? '0 : r_timer + 1'b1;

      // Clear on every phase change, otherwise count cycles without done.
      if (w_state_nx != r_state) begin
        r_stage_cnt <= '0;
      end else if ((r_state != S_WAIT) && !w_stage_done) begin
        r_stage_cnt <= r_stage_cnt + 1'b1;
      end

      e_inp_o  <= (w_state_nx == S_INPUT);
      e_act_o  <= (w_state_nx == S_ACTION);
      e_disp_o <= (w_state_nx == S_DISPLAY);

      if (w_frame_done) begin
        frame_cnt_o <= frame_cnt_o + 8'd1;
      end

      if (w_fault) begin
        timeout_o   <= 1'b1;
        err_stage_o <= r_state;
      end

      overrun_o <= w_tick && (r_state != S_WAIT);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_sequencer
//  Purpose  : Directed self-checking bench for frame_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_frame_sequencer;

  logic clk;
  logic rst_n;
  logic ena;
  logic pause_i;
  logic d_inp, d_act, d_disp;
  logic e_inp, e_act, e_disp;
  logic [1:0] state;
  logic busy;
  logic [7:0] fcnt;
  logic tmo;
  logic [1:0] err;
  logic ovr;

  // Second instance with the watchdog disabled, for the overrun scenario.
  logic z_d_inp, z_d_act, z_d_disp;
  logic z_e_inp, z_e_act, z_e_disp;
  logic [1:0] z_state;
  logic z_busy;
  logic [7:0] z_fcnt;
  logic z_tmo;
  logic [1:0] z_err;
  logic z_ovr;

  int n_vec = 0;
  int n_mis = 0;

  frame_sequencer #(.FRAME_CYCLES(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pause_i(pause_i),
    .e_inp_o(e_inp), .d_inp_i(d_inp),
    .e_act_o(e_act), .d_act_i(d_act),
    .e_disp_o(e_disp), .d_disp_i(d_disp),
    .state_o(state), .busy_o(busy), .frame_cnt_o(fcnt),
    .timeout_o(tmo), .err_stage_o(err), .overrun_o(ovr)
  );

  frame_sequencer #(.FRAME_CYCLES(16), .TIMEOUT(0)) dut_nowd (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pause_i(pause_i),
    .e_inp_o(z_e_inp), .d_inp_i(z_d_inp),
    .e_act_o(z_e_act), .d_act_i(z_d_act),
    .e_disp_o(z_e_disp), .d_disp_i(z_d_disp),
    .state_o(z_state), .busy_o(z_busy), .frame_cnt_o(z_fcnt),
    .timeout_o(z_tmo), .err_stage_o(z_err), .overrun_o(z_ovr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One fastest-possible frame: wait (bounded) for INPUT, then return each
  // done in the first cycle of its enable.
  task automatic do_frame();
    int n;
    n = 0;
    while (!e_inp && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_frame_start", {31'd0, e_inp}, 32'd1);
    d_inp = 1'b1; step(1);
    d_inp = 1'b0; d_act = 1'b1; step(1);
    d_act = 1'b0; d_disp = 1'b1; step(1);
    d_disp = 1'b0;
  endtask

  initial begin : stim
    int cnt;
    logic seen;
    rst_n = 1'b1; ena = 1'b1; pause_i = 1'b0;
    d_inp = 1'b0; d_act = 1'b0; d_disp = 1'b0;
    z_d_inp = 1'b0; z_d_act = 1'b0; z_d_disp = 1'b0;
    #2 rst_n = 1'b0;
    step(2);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_enables", {29'd0, e_inp, e_act, e_disp}, 32'd0);
    chk("rst_status", {20'd0, busy, fcnt, tmo, err}, 32'd0);
    rst_n = 1'b1;

    // First frame: edges counted from 1 after release.
    step(15);
    chk("first_pre_tick", {31'd0, e_inp}, 32'd0);
    step(1);                                   // edge 16
    chk("first_e_inp", {29'd0, e_inp, e_act, e_disp}, 32'b100);
    chk("first_state_inp", {30'd0, state}, 32'b01);
    d_inp = 1'b1; step(1);                     // edge 17
    chk("first_e_act", {29'd0, e_inp, e_act, e_disp}, 32'b010);
    chk("first_state_act", {30'd0, state}, 32'b11);
    d_inp = 1'b0; d_act = 1'b1; step(1);       // edge 18
    chk("first_e_disp", {29'd0, e_inp, e_act, e_disp}, 32'b001);
    d_act = 1'b0; d_disp = 1'b1; step(1);      // edge 19
    d_disp = 1'b0;
    chk("first_done_state", {31'd0, busy, state}, 32'd0);
    chk("first_fcnt", {24'd0, fcnt}, 32'd1);

    // Pause across the decisions at edges 32, 48, 64.
    pause_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      step(1);
      if (e_inp || e_act || e_disp) seen = 1'b1;
    end
    chk("pause_no_enable", {31'd0, seen}, 32'd0);
    pause_i = 1'b0;                            // after edge 64
    step(15);                                  // edge 79
    chk("pause_pre_tick", {31'd0, e_inp}, 32'd0);
    step(1);                                   // edge 80
    chk("pause_resume", {31'd0, e_inp}, 32'd1);

    // Watchdog in ACTION.
    d_inp = 1'b1; step(1);                     // edge 81
    d_inp = 1'b0;
    cnt = e_act ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (e_act) cnt++;
    end                                        // edge 89
    chk("wd_act_cycles", cnt, 32'd8);
    chk("wd_timeout", {31'd0, tmo}, 32'd1);
    chk("wd_err_stage", {30'd0, err}, 32'b11);
    chk("wd_state", {30'd0, state}, 32'b00);
    chk("wd_fcnt", {24'd0, fcnt}, 32'd1);
    step(7);                                   // edge 96
    chk("wd_next_frame", {31'd0, e_inp}, 32'd1);
    chk("wd_sticky", {31'd0, tmo}, 32'd1);

    // Done in the same cycle as the DISPLAY expiry condition.
    d_inp = 1'b1; step(1);                     // edge 97
    d_inp = 1'b0; d_act = 1'b1; step(1);       // edge 98
    d_act = 1'b0;
    step(7);                                   // edge 105, counter = 7
    chk("coll_disp_still", {31'd0, e_disp}, 32'd1);
    d_disp = 1'b1; step(1);                    // edge 106
    d_disp = 1'b0;
    chk("coll_state", {30'd0, state}, 32'b00);
    chk("coll_fcnt", {24'd0, fcnt}, 32'd2);
    chk("coll_err_kept", {30'd0, err}, 32'b11);

    // Freeze mid-ACTION with a stray done during the freeze.
    step(6);                                   // edge 112
    chk("frz_inp", {31'd0, e_inp}, 32'd1);
    d_inp = 1'b1; step(1);                     // edge 113
    d_inp = 1'b0;
    step(2);                                   // edge 115, counter = 2
    ena = 1'b0; d_act = 1'b1;
    step(5);                                   // edges 116..120 frozen
    chk("frz_hold_en", {29'd0, e_inp, e_act, e_disp}, 32'b010);
    chk("frz_hold_state", {30'd0, state}, 32'b11);
    d_act = 1'b0; ena = 1'b1;
    step(5);                                   // edge 125, counter = 7
    chk("frz_act_before_abort", {31'd0, e_act}, 32'd1);
    step(1);                                   // edge 126
    chk("frz_abort", {31'd0, e_act}, 32'd0);
    chk("frz_fcnt", {24'd0, fcnt}, 32'd2);
    step(6);                                   // edge 132
    chk("frz_timer_held", {31'd0, e_inp}, 32'd0);
    step(1);                                   // edge 133
    chk("frz_next_inp", {31'd0, e_inp}, 32'd1);

    // Asynchronous reset mid-INPUT.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_enables", {29'd0, e_inp, e_act, e_disp}, 32'd0);
    chk("arst_status", {22'd0, busy, state, fcnt, tmo}, 32'd0);
    chk("arst_err_ovr", {29'd0, err, ovr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 256 frames wrap the frame counter.
    for (int f = 0; f < 255; f++) do_frame();
    chk("wrap_255", {24'd0, fcnt}, 32'd255);
    do_frame();
    chk("wrap_0", {24'd0, fcnt}, 32'd0);

    // Overrun on the watchdog-free instance.
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(16);                                  // edge 16
    chk("ovr_inp", {31'd0, z_e_inp}, 32'd1);
    z_d_inp = 1'b1; step(1);                   // edge 17
    z_d_inp = 1'b0; z_d_act = 1'b1; step(1);   // edge 18
    z_d_act = 1'b0;
    step(13);                                  // edge 31
    chk("ovr_pre", {31'd0, z_ovr}, 32'd0);
    step(1);                                   // edge 32
    chk("ovr_pulse", {31'd0, z_ovr}, 32'd1);
    chk("ovr_disp_continues", {31'd0, z_e_disp}, 32'd1);
    step(1);                                   // edge 33
    chk("ovr_one_cycle", {31'd0, z_ovr}, 32'd0);
    step(4);                                   // edge 37
    chk("ovr_no_watchdog", {31'd0, z_e_disp}, 32'd1);
    z_d_disp = 1'b1; step(1);                  // edge 38
    z_d_disp = 1'b0;
    chk("ovr_done_state", {30'd0, z_state}, 32'b00);
    chk("ovr_fcnt", {24'd0, z_fcnt}, 32'd1);
    step(9);                                   // edge 47
    chk("ovr_skip_tick", {31'd0, z_e_inp}, 32'd0);
    step(1);                                   // edge 48
    chk("ovr_next_inp", {31'd0, z_e_inp}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_sequencer.md
# frame_sequencer

Paced controller for the game's three-stage datapath (input sampling, game action, matrix display). It replaces the free-running enable/done ring in the top level. Each frame runs INPUT → ACTION → DISPLAY under enable/done handshakes, starting only on a frame-rate tick. A per-stage watchdog aborts a stalled stage, and status flags report the active phase, completed frames and faults.

## Interface
- FRAME_CYCLES, default 16: clock cycles per frame tick; must be ≥ 2.
- TIMEOUT, default 8: maximum cycles a stage enable may stay high without done; 0 disables the watchdog.
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- ena, input, 1: design enable; low freezes all state, counters and outputs.
- pause_i, input, 1: while high, no new frame starts.
- e_inp_o, output, 1: enable to the input stage.
- d_inp_i, input, 1: done from the input stage.
- e_act_o, output, 1: enable to the action stage.
- d_act_i, input, 1: done from the action stage.
- e_disp_o, output, 1: enable to the display stage.
- d_disp_i, input, 1: done from the display stage.
- state_o, output, 2: current phase; WAIT=00, INPUT=01, ACTION=11, DISPLAY=10.
- busy_o, output, 1: high when state_o ≠ WAIT.
- frame_cnt_o, output, 8: number of completed frames, wraps.
- timeout_o, output, 1: sticky watchdog fault flag.
- err_stage_o, output, 2: state code of the stage that timed out; holds the most recent fault.
- overrun_o, output, 1: one-cycle pulse on a frame tick that arrives outside WAIT.

## Operation
- Reset values: state WAIT, frame timer 0, stage counter 0. All enables 0, frame_cnt_o 0, timeout_o 0, err_stage_o 00, overrun_o 0, busy_o 0.
- Frame timer: counts 0..FRAME_CYCLES-1 and wraps. tick = (timer == FRAME_CYCLES-1). It runs in every state while ena is high.
- WAIT → INPUT when tick && !pause_i.
- WAIT with tick && pause_i: stay in WAIT. This is not an overrun.
- INPUT → ACTION when d_inp_i is sampled high.
- ACTION → DISPLAY when d_act_i is sampled high.
- DISPLAY → WAIT when d_disp_i is sampled high; frame_cnt_o increments at the same time (255 → 0).
- Exactly one enable is high in INPUT, ACTION and DISPLAY; all enables are low in WAIT. Enables are registered outputs decoded from the next state.
- A done input is ignored unless its own enable is currently high. Stray or early dones from other stages have no effect.
- Watchdog:
  - The stage counter clears on entry to every stage and increments each cycle the stage's done is low.
  - When the counter reaches TIMEOUT-1 with done still low, the stage aborts: enable drops, state → WAIT, timeout_o ← 1, err_stage_o ← stage code.
  - frame_cnt_o is not incremented on an abort.
- Done in the same cycle as the timeout condition: done wins and no fault is raised.
- Overrun: a tick while state ≠ WAIT pulses overrun_o. The frame in progress continues; the next frame waits for the following tick.
- ena low: all registers hold and done inputs are ignored. Operation resumes exactly where it stopped.
- rst_n asserted mid-frame: immediate asynchronous return to the reset values, including clearing the sticky timeout_o.

## Timing
- With ena high from reset release, tick occurs in cycle FRAME_CYCLES-1. e_inp_o rises at the FRAME_CYCLES-th rising edge.
- Done sampled high at edge k: the current enable falls and the next enable rises at that same edge k. There is no gap cycle between stages.
- Minimum frame: 3 cycles of enables (each done returned in the first enable cycle), then WAIT until the next tick.
- Watchdog: an enable stays high for at most TIMEOUT cycles and falls at the TIMEOUT-th edge after it rose.
- overrun_o is high for exactly the one cycle after the tick edge.
- busy_o, state_o and the enables change only on clk edges, except on asynchronous reset.

## Test plan
- Reset and first frame (FRAME_CYCLES=16): release rst_n, each stage returns done 1 cycle after its enable → e_inp_o rises at edge 16; e_act_o and e_disp_o follow with no gaps; frame_cnt_o=1; state_o=00 after DISPLAY done.
- Pause: hold pause_i=1 across 3 ticks, then release → no enable pulses while paused; INPUT starts at the first tick after release.
- Watchdog (TIMEOUT=8): ACTION never returns done → e_act_o high exactly 8 cycles; timeout_o=1; err_stage_o=11; frame_cnt_o unchanged; next frame starts at the next tick with timeout_o still 1.
- Done/timeout collision: d_disp_i asserted in the cycle where the counter reaches 7 → no fault; frame_cnt_o increments.
- Overrun: DISPLAY delays done 20 cycles (TIMEOUT=0) → overrun_o pulses once at the tick; INPUT starts at the following tick.
- Freeze and wrap: drop ena for 5 cycles mid-ACTION → enables and counters hold, and a d_act_i pulse during the freeze is ignored. Separately, run 256 frames → frame_cnt_o wraps to 0. Finally assert rst_n low mid-INPUT → all outputs return to their reset values immediately.
